// File: rtl/clean_countdown_display.sv
// Converts the self-clean seconds countdown to M:SS with an iterative divider.
// It drives a 4-digit multiplexed 7-segment display in one of three modes: live, flash or blank.
module clean_countdown_display #(
   parameter int unsigned SCAN_DIV    = 100_000,
   parameter int unsigned BLINK_DIV   = 25_000_000,
   parameter int unsigned DONE_BLINKS = 6
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cleaning_i,
   input  logic [7:0] countdown_i,
   input  logic       done_i,
   output logic       busy_o,
   output logic [3:0] an_o,
   output logic [7:0] seg_o
);
   localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int unsigned HalfW  = (DONE_BLINKS > 1) ? $clog2(DONE_BLINKS) : 1;

   typedef enum logic [1:0] {StIdle, StMin, StSec, StLoad} conv_state_e;

   conv_state_e       state_q, state_d;
   logic [7:0]        rem_q, rem_d, last_cnt_q, last_cnt_d;
   logic [3:0]        mins_q, mins_d, tens_q, tens_d;
   logic [3:0]        dig_min_q, dig_min_d, dig_tens_q, dig_tens_d, dig_ones_q, dig_ones_d;
   logic              busy_q, busy_d;
   logic              clean_q, done_q;
   logic              flash_q, flash_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic [HalfW-1:0]  half_q, half_d;
   logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
   logic [1:0]        scan_idx_q, scan_idx_d;
   logic [3:0]        an_q, an_d;
   logic [7:0]        seg_q, seg_d;
   logic              clean_rise, done_rise, lit;
   logic [3:0]        digit;

   assign clean_rise = cleaning_i & ~clean_q;
   assign done_rise  = done_i & ~done_q;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h00;
      endcase
   endfunction

   // Conversion: repeated subtraction of 60 then 10, one step per cycle.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      last_cnt_d = last_cnt_q;
      mins_d     = mins_q;
      tens_d     = tens_q;
      busy_d     = busy_q;
      dig_min_d  = dig_min_q;
      dig_tens_d = dig_tens_q;
      dig_ones_d = dig_ones_q;
      case (state_q)
         StIdle: begin
            if (cleaning_i && ((countdown_i != last_cnt_q) || clean_rise)) begin
               rem_d      = countdown_i;
               last_cnt_d = countdown_i;
               mins_d     = 4'd0;
               tens_d     = 4'd0;
               busy_d     = 1'b1;
               state_d    = StMin;
            end
         end
         StMin: begin
            if (rem_q >= 8'd60) begin
               rem_d  = rem_q - 8'd60;
               mins_d = mins_q + 4'd1;
            end else begin
               state_d = StSec;
            end
         end
         StSec: begin
            if (rem_q >= 8'd10) begin
               rem_d  = rem_q - 8'd10;
               tens_d = tens_q + 4'd1;
            end else begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            dig_min_d  = mins_q;
            dig_tens_d = tens_q;
            dig_ones_d = rem_q[3:0];
            busy_d     = 1'b0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Flash sequencing; a done edge wins over a simultaneous cleaning edge.
   always_comb begin
      flash_d     = flash_q;
      blink_cnt_d = blink_cnt_q;
      half_d      = half_q;
      if (done_rise) begin
         flash_d     = 1'b1;
         blink_cnt_d = '0;
         half_d      = '0;
      end else if (clean_rise) begin
         flash_d = 1'b0;
      end else if (flash_q) begin
         if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            if (half_q == HalfW'(DONE_BLINKS - 1)) begin
               flash_d = 1'b0;
               half_d  = '0;
            end else begin
               half_d = half_q + HalfW'(1);
            end
         end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
         end
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + ScanW'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         scan_idx_d = scan_idx_q + 2'd1;
      end
   end

   // Outputs are built from next-state so an/seg change together on one edge.
   always_comb begin
      an_d  = 4'b0000;
      seg_d = 8'h00;
      digit = 4'd0;
      lit   = flash_d ? ~half_d[0] : cleaning_i;
      if (!flash_d) begin
         case (scan_idx_d)
            2'd0:    digit = dig_ones_d;
            2'd1:    digit = dig_tens_d;
            default: digit = dig_min_d;
         endcase
      end
      if (lit && (scan_idx_d != 2'd3)) begin
         an_d  = 4'b0001 << scan_idx_d;
         seg_d = {(scan_idx_d == 2'd2), decode(digit)};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         last_cnt_q  <= '0;
         mins_q      <= '0;
         tens_q      <= '0;
         busy_q      <= 1'b0;
         dig_min_q   <= '0;
         dig_tens_q  <= '0;
         dig_ones_q  <= '0;
         clean_q     <= 1'b0;
         done_q      <= 1'b0;
         flash_q     <= 1'b0;
         blink_cnt_q <= '0;
         half_q      <= '0;
         scan_cnt_q  <= '0;
         scan_idx_q  <= '0;
         an_q        <= '0;
         seg_q       <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         last_cnt_q  <= last_cnt_d;
         mins_q      <= mins_d;
         tens_q      <= tens_d;
         busy_q      <= busy_d;
         dig_min_q   <= dig_min_d;
         dig_tens_q  <= dig_tens_d;
         dig_ones_q  <= dig_ones_d;
         clean_q     <= cleaning_i;
         done_q      <= done_i;
         flash_q     <= flash_d;
         blink_cnt_q <= blink_cnt_d;
         half_q      <= half_d;
         scan_cnt_q  <= scan_cnt_d;
         scan_idx_q  <= scan_idx_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign busy_o = busy_q;
   assign an_o   = an_q;
   assign seg_o  = seg_q;

endmodule

// File: tb/tb_clean_countdown_display.sv
// Bench for clean_countdown_display: directed scenarios plus random stimulus,
// every cycle compared against an arithmetic model of conversion, flash and scan.
module tb_clean_countdown_display;
   localparam int unsigned ScanDiv    = 4;
   localparam int unsigned BlinkDiv   = 16;
   localparam int unsigned DoneBlinks = 6;

   logic       clk_i = 1'b0;
   logic       rst_ni, cleaning_i, done_i;
   logic [7:0] countdown_i;
   logic       busy_o;
   logic [3:0] an_o;
   logic [7:0] seg_o;

   clean_countdown_display #(
      .SCAN_DIV   (ScanDiv),
      .BLINK_DIV  (BlinkDiv),
      .DONE_BLINKS(DoneBlinks)
   ) u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cleaning_i (cleaning_i),
      .countdown_i(countdown_i),
      .done_i     (done_i),
      .busy_o     (busy_o),
      .an_o       (an_o),
      .seg_o      (seg_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: time since reset, pending conversion, shown digits, flash age.
   int m_k, m_last, m_busy_left, m_val, m_min, m_ten, m_one, m_age;
   bit m_cl_prev, m_dn_prev, m_flash;
   logic [7:0] seg_tab [10];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_k = 0; m_last = 0; m_busy_left = 0; m_val = 0;
      m_min = 0; m_ten = 0; m_one = 0; m_age = 0;
      m_cl_prev = 0; m_dn_prev = 0; m_flash = 0;
   endtask

   // One clock: drive inputs, advance the model, compare all outputs.
   task automatic step(input bit rst_n, input bit cl, input int cd, input bit dn);
      bit   cr, dr, lit;
      int   idx, dig;
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      rst_ni = rst_n; cleaning_i = cl; countdown_i = 8'(cd); done_i = dn;
      @(posedge clk_i);
      #1;
      if (!rst_n) begin
         model_reset();
      end else begin
         cr = cl && !m_cl_prev;
         dr = dn && !m_dn_prev;
         m_k++;
         if (m_busy_left == 0) begin
            if (cl && (cd != m_last || cr)) begin
               m_val = cd;
               m_last = cd;
               m_busy_left = cd / 60 + (cd % 60) / 10 + 3;
            end
         end else begin
            m_busy_left--;
            if (m_busy_left == 0) begin
               m_min = m_val / 60;
               m_ten = (m_val % 60) / 10;
               m_one = m_val % 10;
            end
         end
         if (dr) begin
            m_flash = 1; m_age = 0;
         end else if (cr) begin
            m_flash = 0;
         end else if (m_flash) begin
            m_age++;
            if (m_age >= int'(BlinkDiv * DoneBlinks)) m_flash = 0;
         end
         m_cl_prev = cl;
         m_dn_prev = dn;
      end
      idx = (m_k / int'(ScanDiv)) % 4;
      lit = m_flash ? (((m_age / int'(BlinkDiv)) % 2) == 0) : cl;
      exp_an = 4'b0000;
      exp_seg = 8'h00;
      if (rst_n && lit && idx != 3) begin
         dig = m_flash ? 0 : (idx == 0 ? m_one : (idx == 1 ? m_ten : m_min));
         exp_an = 4'b0001 << idx;
         exp_seg = seg_tab[dig] | ((idx == 2) ? 8'h80 : 8'h00);
      end
      check("an", 32'(an_o), 32'(exp_an));
      check("seg", 32'(seg_o), 32'(exp_seg));
      check("busy", 32'(busy_o), 32'(m_busy_left > 0));
   endtask

   int busy_cnt, lit_cnt;
   bit r_rst, r_cl, r_dn;
   int r_cd;

   initial begin
      seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
      model_reset();
      rst_ni = 1'b0; cleaning_i = 1'b0; countdown_i = 8'd0; done_i = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // Live conversion of 18, then the 4:15 worst case, 1:00 and 0:00.
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 18, 0);
         busy_cnt += int'(busy_o);
      end
      check("busy18", 32'(busy_cnt), 32'd4);
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 255, 0);
         busy_cnt += int'(busy_o);
      end
      check("busy255", 32'(busy_cnt), 32'd8);
      repeat (40) step(1, 1, 60, 0);
      repeat (40) step(1, 1, 0, 0);

      // Countdown changes while busy.
      step(1, 1, 18, 0);
      repeat (30) step(1, 1, 17, 0);

      // Cleaning ends, single done pulse, then done held high.
      repeat (10) step(1, 0, 17, 0);
      step(1, 0, 17, 1);
      repeat (120) step(1, 0, 17, 0);
      lit_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1, 0, 17, 1);
         lit_cnt += int'(an_o != 4'b0000);
      end
      check("flash_lit", 32'(lit_cnt), 32'd36);
      step(1, 0, 17, 0);

      // Cleaning rises during flash.
      step(1, 0, 17, 1);
      repeat (20) step(1, 0, 17, 0);
      repeat (30) step(1, 1, 42, 0);

      // Reset mid-conversion and mid-flash.
      step(1, 1, 200, 0);
      step(1, 1, 200, 0);
      step(0, 1, 200, 0);
      repeat (3) step(1, 0, 200, 0);
      step(1, 0, 200, 1);
      repeat (5) step(1, 0, 200, 0);
      step(0, 0, 200, 0);
      repeat (5) step(1, 0, 200, 0);

      // Random traffic.
      r_cl = 0; r_dn = 0; r_cd = 0;
      for (int i = 0; i < 4000; i++) begin
         r_rst = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 59) == 0) r_cl = ~r_cl;
         if ($urandom_range(0, 9) == 0) r_cd = int'($urandom_range(0, 255));
         if ($urandom_range(0, 79) == 0) r_dn = ~r_dn;
         step(r_rst, r_cl, r_cd, r_dn);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
